// File: rtl/e_gpu_sram_pkg.sv
// Shared types and constants for the behavioural multi-port SRAM.
// Used by sram_port_ctrl and multi_port_sram_behavioral.
package e_gpu_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sram_state_t;

  localparam int unsigned SRAM_BE_W        = 4;
  localparam int unsigned SRAM_WORD_W      = 32;
  localparam int unsigned MAX_READ_LATENCY = 8;
  localparam int unsigned SRAM_CNT_W       = $clog2(MAX_READ_LATENCY + 1);

endpackage

// File: rtl/sram_port_ctrl.sv
// One SRAM port: request/response FSM, latency down-counter, response holding registers.
// Error reporting is built only when SRAM_ERR_RESP_EN is defined.
//
//   state | meaning
//   IDLE  | no access outstanding; grant follows req
//   WAIT  | access accepted, counting down to the response cycle
//   RESP  | rvalid high for this cycle; a new request may be granted
module sram_port_ctrl
  import e_gpu_sram_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
`ifdef SRAM_ERR_RESP_EN
  ,
  parameter bit          WRITE_EN     = 1'b0
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [SRAM_WORD_W-1:0] rd_word_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [SRAM_WORD_W-1:0] rdata_o
`ifdef SRAM_ERR_RESP_EN
  ,
  input  logic                   addr_err_i,
  output logic                   err_o
`endif
);

  localparam logic [SRAM_CNT_W-1:0] LAT_M1 = SRAM_CNT_W'(READ_LATENCY - 1);

  sram_state_t            state_q;
  logic [SRAM_CNT_W-1:0]  cnt_q;
  logic [SRAM_WORD_W-1:0] hold_q;
  logic                   rvalid_q;
  logic                   drop_data;

`ifdef SRAM_ERR_RESP_EN
  logic err_cond;
  logic err_q;

  assign err_cond  = addr_err_i | (we_i & ~WRITE_EN);
  assign drop_data = we_i | addr_err_i;
  assign err_o     = rvalid_q & err_q;
`else
  assign drop_data = we_i;
`endif

  assign gnt_o    = req_i & (state_q != WAIT);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rvalid_q ? hold_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      rvalid_q <= 1'b0;
`ifdef SRAM_ERR_RESP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (gnt_o) begin
            // Array is sampled here, before this edge's writes land.
            hold_q <= drop_data ? '0 : rd_word_i;
`ifdef SRAM_ERR_RESP_EN
            err_q  <= err_cond;
`endif
            if (READ_LATENCY > 1) begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end else begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - SRAM_CNT_W'(1);
          if (cnt_q == SRAM_CNT_W'(1)) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ERR_RESP_EN
  always_ff @(posedge clk_i) begin
    if (rst_ni && gnt_o && err_cond) begin
      $warning("sram_port_ctrl: erroneous access (out of range address or write to read-only port)");
    end
  end
`endif

endmodule

// File: rtl/multi_port_sram_behavioral.sv
// Behavioural word-addressed SRAM with NUM_PORTS independent OBI-style ports.
// Optional error responses are enabled with the SRAM_ERR_RESP_EN macro.
module multi_port_sram_behavioral
  import e_gpu_sram_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTE   = 32768,
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned READ_LATENCY    = 1,
  parameter logic [7:0]  WRITE_PORT_MASK = 8'b10
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS*SRAM_BE_W-1:0]   be_i,
  input  logic [NUM_PORTS*32-1:0]          addr_i,
  input  logic [NUM_PORTS*SRAM_WORD_W-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [NUM_PORTS*SRAM_WORD_W-1:0] rdata_o
`ifdef SRAM_ERR_RESP_EN
  ,
  output logic [NUM_PORTS-1:0]             err_o
`endif
);

  localparam int unsigned AW    = $clog2(MEM_SIZE_BYTE);
  localparam int unsigned IDX_W = AW - 2;
  localparam int unsigned WORDS = MEM_SIZE_BYTE / 4;

  logic [SRAM_WORD_W-1:0] mem_q [WORDS];
  logic [IDX_W-1:0]       idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]   wr_en;
  logic [NUM_PORTS-1:0]   addr_err;
  logic [NUM_PORTS-1:0]   unused_addr_bits;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign idx[p]              = addr_i[32*p+2 +: IDX_W];
    assign unused_addr_bits[p] = ^{addr_i[32*p +: 2], addr_i[32*p+AW +: 32-AW]};
`ifdef SRAM_ERR_RESP_EN
    assign addr_err[p] = |addr_i[32*p+AW +: 32-AW];
`else
    assign addr_err[p] = 1'b0;
`endif
    assign wr_en[p] = rst_ni & gnt_o[p] & we_i[p] & WRITE_PORT_MASK[p] & ~addr_err[p];

    sram_port_ctrl #(
      .READ_LATENCY (READ_LATENCY)
`ifdef SRAM_ERR_RESP_EN
      ,
      .WRITE_EN     (WRITE_PORT_MASK[p])
`endif
    ) u_ctrl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i[p]),
      .we_i       (we_i[p]),
      .rd_word_i  (mem_q[idx[p]]),
      .gnt_o      (gnt_o[p]),
      .rvalid_o   (rvalid_o[p]),
      .rdata_o    (rdata_o[SRAM_WORD_W*p +: SRAM_WORD_W])
`ifdef SRAM_ERR_RESP_EN
      ,
      .addr_err_i (addr_err[p]),
      .err_o      (err_o[p])
`endif
    );
  end

  // Ports are visited in ascending order, so the highest-index writer of a byte wins.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < SRAM_BE_W; b++) begin
        if (wr_en[p] && be_i[SRAM_BE_W*p+b]) begin
          mem_q[idx[p]][8*b +: 8] <= wdata_i[SRAM_WORD_W*p+8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_sram_behavioral.sv
// Directed bench for multi_port_sram_behavioral: three instances cover
// 2 ports/latency 1, 2 ports/latency 3 and 4 ports with two writers.
module tb_multi_port_sram_behavioral;

`ifdef SRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rst_b_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: 2 ports, latency 1, port1 writable
  logic [1:0]  req_a, we_a, gnt_a, rvalid_a, err_a;
  logic [7:0]  be_a;
  logic [63:0] addr_a, wdata_a, rdata_a;
  // instance b: 2 ports, latency 3, port1 writable
  logic [1:0]  req_b, we_b, gnt_b, rvalid_b, err_b;
  logic [7:0]  be_b;
  logic [63:0] addr_b, wdata_b, rdata_b;
  // instance c: 4 ports, latency 1, ports 2 and 3 writable
  logic [3:0]   req_c, we_c, gnt_c, rvalid_c, err_c;
  logic [15:0]  be_c;
  logic [127:0] addr_c, wdata_c, rdata_c;

  multi_port_sram_behavioral #(.MEM_SIZE_BYTE(32768), .NUM_PORTS(2), .READ_LATENCY(1),
                               .WRITE_PORT_MASK(8'b10)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a), .be_i(be_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a)
`ifdef SRAM_ERR_RESP_EN
    , .err_o(err_a)
`endif
  );

  multi_port_sram_behavioral #(.MEM_SIZE_BYTE(32768), .NUM_PORTS(2), .READ_LATENCY(3),
                               .WRITE_PORT_MASK(8'b10)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .req_i(req_b), .we_i(we_b), .be_i(be_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b)
`ifdef SRAM_ERR_RESP_EN
    , .err_o(err_b)
`endif
  );

  multi_port_sram_behavioral #(.MEM_SIZE_BYTE(32768), .NUM_PORTS(4), .READ_LATENCY(1),
                               .WRITE_PORT_MASK(8'b1100)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .we_i(we_c), .be_i(be_c), .addr_i(addr_c),
    .wdata_i(wdata_c), .gnt_o(gnt_c), .rvalid_o(rvalid_c), .rdata_o(rdata_c)
`ifdef SRAM_ERR_RESP_EN
    , .err_o(err_c)
`endif
  );

`ifndef SRAM_ERR_RESP_EN
  assign err_a = '0;
  assign err_b = '0;
  assign err_c = '0;
`endif

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    req_a = '0; we_a = '0; be_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; be_b = '0; addr_b = '0; wdata_b = '0;
    req_c = '0; we_c = '0; be_c = '0; addr_c = '0; wdata_c = '0;
  endtask

  // single transaction on instance a, response expected one cycle after grant
  task automatic run_a(input vec_t v, input int id);
    @(negedge clk);
    req_a = '0; we_a = '0;
    req_a[v.port]          = 1'b1;
    we_a[v.port]           = v.we;
    be_a[4*v.port +: 4]    = v.be;
    addr_a[32*v.port +: 32]  = v.addr;
    wdata_a[32*v.port +: 32] = v.wdata;
    #1 check($sformatf("vec%0d gnt", id), 128'(gnt_a[v.port]), 128'(1'b1));
    @(negedge clk);
    req_a = '0; we_a = '0;
    #1;
    check($sformatf("vec%0d rvalid", id), 128'(rvalid_a[v.port]), 128'(1'b1));
    check($sformatf("vec%0d rdata", id), 128'(rdata_a[32*v.port +: 32]), 128'(v.exp_rdata));
    if (ERR_EN) check($sformatf("vec%0d err", id), 128'(err_a[v.port]), 128'(v.exp_err));
  endtask

  task automatic run_c(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string name);
    @(negedge clk);
    req_c = '0; we_c = '0;
    req_c[port] = 1'b1; we_c[port] = we; be_c[4*port +: 4] = 4'hF;
    addr_c[32*port +: 32] = addr; wdata_c[32*port +: 32] = wdata;
    #1 check({name, " gnt"}, 128'(gnt_c), 128'(4'b0001 << port));
    @(negedge clk);
    req_c = '0; we_c = '0;
    #1;
    check({name, " rvalid"}, 128'(rvalid_c), 128'(4'b0001 << port));
    check({name, " rdata"}, 128'(rdata_c[32*port +: 32]), 128'(exp));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  gp, rp;
    logic [31:0] rd_cap;
    logic        rv_seen;

    //        port we  be    addr           wdata         expected rdata                  err
    tbl[0]  = '{1, 1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,                           1'b0};
    tbl[1]  = '{0, 0, 4'hF, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF,                   1'b0};
    tbl[2]  = '{1, 1, 4'hF, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0,                           1'b0};
    tbl[3]  = '{1, 1, 4'h5, 32'h0000_0044, 32'h1122_3344, 32'h0,                           1'b0};
    tbl[4]  = '{0, 0, 4'hF, 32'h0000_0044, 32'h0,         32'hFF22_FF44,                   1'b0};
    tbl[5]  = '{0, 1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0,                           ERR_EN};
    tbl[6]  = '{1, 0, 4'hF, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF,                   1'b0};
    tbl[7]  = '{1, 1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,                           1'b0};
    tbl[8]  = '{0, 0, 4'hF, 32'h0000_8000, 32'h0,         ERR_EN ? 32'h0 : 32'hCAFE_F00D,  ERR_EN};
    tbl[9]  = '{1, 1, 4'hF, 32'h0000_7FFC, 32'h0BAD_C0DE, 32'h0,                           1'b0};
    tbl[10] = '{0, 0, 4'hF, 32'h0000_7FFC, 32'h0,         32'h0BAD_C0DE,                   1'b0};
    tbl[11] = '{1, 0, 4'hF, 32'hFFFF_0044, 32'h0,         ERR_EN ? 32'h0 : 32'hFF22_FF44,  ERR_EN};
    tbl[12] = '{1, 1, 4'hF, 32'h0000_8000, 32'h7777_7777, 32'h0,                           ERR_EN};
    tbl[13] = '{0, 0, 4'hF, 32'h0000_0000, 32'h0,         ERR_EN ? 32'hCAFE_F00D : 32'h7777_7777, 1'b0};
    tbl[14] = '{1, 1, 4'hF, 32'h0000_0080, 32'h0,         32'h0,                           1'b0};

    idle_all();
    rst_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset rvalid_a", 128'(rvalid_a), 128'(0));
    check("reset rdata_a", 128'(rdata_a), 128'(0));
    check("reset err_a", 128'(err_a), 128'(0));
    check("reset rvalid_c", 128'(rvalid_c), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    req_a = 2'b10;
    #1 check("post-reset gnt_a", 128'(gnt_a), 128'(2'b10));
    req_a = 2'b00;
    #1 check("post-reset gnt_a idle", 128'(gnt_a), 128'(2'b00));

    for (int i = 0; i < NV; i++) run_a(tbl[i], i);

    // same-edge read on port0 and write on port1 to word 0x80
    @(negedge clk);
    req_a = 2'b11; we_a = 2'b10; be_a = 8'hF0;
    addr_a = {32'h0000_0080, 32'h0000_0080};
    wdata_a = {32'h0000_0005, 32'h0};
    #1 check("rw gnt", 128'(gnt_a), 128'(2'b11));
    @(negedge clk);
    idle_all();
    #1;
    check("rw rvalid", 128'(rvalid_a), 128'(2'b11));
    check("rw rdata", 128'(rdata_a), 128'(0));
    run_a('{0, 0, 4'hF, 32'h0000_0080, 32'h0, 32'h0000_0005, 1'b0}, 100);

    // latency 3: seed word 0x10, then back-to-back reads with req held
    @(negedge clk);
    req_b = 2'b10; we_b = 2'b10; be_b = 8'hF0;
    addr_b = {32'h0000_0010, 32'h0}; wdata_b = {32'h1357_9BDF, 32'h0};
    @(negedge clk);
    idle_all();
    repeat (4) @(negedge clk);
    req_b = 2'b01; addr_b = {32'h0, 32'h0000_0010};
    gp = '0; rp = '0; rd_cap = '0;
    for (int k = 0; k < 7; k++) begin
      #1;
      gp[k] = gnt_b[0];
      rp[k] = rvalid_b[0];
      if (k == 3) rd_cap = rdata_b[31:0];
      @(negedge clk);
    end
    idle_all();
    check("lat3 gnt pattern", 128'(gp), 128'(7'b1001001));
    check("lat3 rvalid pattern", 128'(rp), 128'(7'b1001000));
    check("lat3 rdata", 128'(rd_cap), 128'(32'h1357_9BDF));
    repeat (4) @(negedge clk);

    // reset asserted while port0 is in WAIT
    req_b = 2'b01; addr_b = {32'h0, 32'h0000_0010};
    @(negedge clk);
    #1 check("wait gnt low", 128'(gnt_b[0]), 128'(1'b0));
    idle_all();
    #1 rst_b_n = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst_b_n = 1'b1;
      #1 rv_seen = rv_seen | (|rvalid_b);
    end
    check("reset-in-wait rvalid", 128'(rv_seen), 128'(1'b0));
    req_b = 2'b10; addr_b = {32'h0000_0010, 32'h0};
    #1 check("reset-in-wait idle gnt", 128'(gnt_b), 128'(2'b10));
    @(negedge clk);
    idle_all();
    repeat (2) @(negedge clk);
    #1;
    check("retained rvalid", 128'(rvalid_b), 128'(2'b10));
    check("retained rdata", 128'(rdata_b[63:32]), 128'(32'h1357_9BDF));

    // four ports: same-edge writes from ports 2 and 3 to one word
    @(negedge clk);
    req_c = 4'b1100; we_c = 4'b1100; be_c = 16'h3F00;
    addr_c = {32'h0000_0100, 32'h0000_0100, 64'h0};
    wdata_c = {32'h5555_5555, 32'hAAAA_AAAA, 64'h0};
    #1 check("ww gnt", 128'(gnt_c), 128'(4'b1100));
    @(negedge clk);
    idle_all();
    #1;
    check("ww rvalid", 128'(rvalid_c), 128'(4'b1100));
    check("ww rdata", rdata_c, 128'(0));
    run_c(1, 1'b0, 32'h0000_0100, 32'h0,         32'hAAAA_5555, "ww read");
    run_c(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0,         "ro write");
    run_c(3, 1'b0, 32'h0000_0100, 32'h0,         32'hAAAA_5555, "ro read");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
